flit_tx_arbiter: RTL and testbench

- Packet-atomic round-robin arbiter sharing one flit transmit port between NUM_REQ requesters.
- Typical requesters: local packet generator, routing forwarder, ack responder.
- Sits between those sources and the node's packet controller / link transmitter.
- Once a requester is granted, the grant is held until that requester's last flit is accepted, so packets never interleave on the link.
- A flit-count guard releases the port if a requester never signals last.

---
 rtl/flit_tx_arbiter.sv | 125 ++++++++++++
 tb/tb_flit_tx_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flit_tx_arbiter.sv
// flit_tx_arbiter
// Packet-atomic round-robin arbiter that shares one flit transmit port
// between NUM_REQ requesters. A granted requester keeps the port until its
// last flit is accepted, or until MAX_FLITS flits have gone without a last
// marker, in which case the port is forcibly released and overrun pulses.
//
// Handshake: a flit moves on any cycle where valid and ready are both high
// at the rising edge of clk. The sender holds valid, flit and last stable
// until that happens. The receiver may raise or lower ready at any time.
//
// Ports
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   req_valid  per-requester flit valid
//   req_flit   per-requester flit, requester i at [i*FLIT_WIDTH +: FLIT_WIDTH]
//   req_last   per-requester last-flit-of-packet marker
//   req_ready  per-requester ready; only the owner's bit can be set
//   out_valid  flit valid toward the transmitter
//   out_flit   granted flit
//   out_last   granted last marker
//   out_ready  transmitter ready
//   grant_id   current owner index; meaningful while busy=1
//   busy       a packet is in progress (LOCKED state)
//   overrun    one-cycle pulse after a forced release
module flit_tx_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int FLIT_WIDTH = 64,
  parameter int MAX_FLITS  = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*FLIT_WIDTH-1:0] req_flit,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          out_valid,
  output logic [FLIT_WIDTH-1:0]         out_flit,
  output logic                          out_last,
  input  logic                          out_ready,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy,
  output logic                          overrun
);

  localparam int GW = $clog2(NUM_REQ);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t        state;
  logic [GW-1:0] rr_ptr;
  logic [7:0]    flit_cnt;

  logic [GW-1:0] pick;
  logic          found;
  logic          transfer;
  logic [7:0]    cnt_inc;
  logic [GW-1:0] rr_next;

  // Round-robin search starting at rr_ptr, wrapping past NUM_REQ-1 to 0.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int idx;
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        pick  = GW'(idx);
        found = 1'b1;
      end
    end
  end

  // The flit path is purely combinational once locked, so the owner sees
  // the transmitter directly and no flit is ever stored here.
  assign busy      = (state == LOCKED);
  assign out_valid = busy & req_valid[grant_id];
  assign out_last  = busy & req_last[grant_id];
  assign out_flit  = busy ? req_flit[grant_id*FLIT_WIDTH +: FLIT_WIDTH] : '0;

  always_comb begin
    req_ready = '0;
    if (busy) req_ready[grant_id] = out_ready;
  end

  assign transfer = out_valid & out_ready;
  assign cnt_inc  = (flit_cnt == 8'hFF) ? flit_cnt : flit_cnt + 8'd1;
  assign rr_next  = (grant_id == GW'(NUM_REQ - 1)) ? '0 : grant_id + GW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      grant_id <= '0;
      flit_cnt <= '0;
      overrun  <= 1'b0;
    end else begin
      overrun <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            grant_id <= pick;
            flit_cnt <= '0;
            state    <= LOCKED;
          end
        end
        LOCKED: begin
          if (transfer) begin
            flit_cnt <= cnt_inc;
            // A last marker wins over the flit limit on the same transfer.
            if (out_last) begin
              state  <= IDLE;
              rr_ptr <= rr_next;
            end else if (cnt_inc >= 8'(MAX_FLITS)) begin
              state   <= IDLE;
              rr_ptr  <= rr_next;
              overrun <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flit_tx_arbiter.sv
module tb_flit_tx_arbiter;

  localparam int NR = 3;
  localparam int FW = 16;
  localparam int MF = 4;
  localparam int GW = 2;
  localparam int EW = GW + 1 + FW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NR-1:0]    req_valid = '0;
  logic [NR*FW-1:0] req_flit = '0;
  logic [NR-1:0]    req_last = '0;
  logic [NR-1:0]    req_ready;
  logic             out_valid;
  logic [FW-1:0]    out_flit;
  logic             out_last;
  logic             out_ready = 1'b1;
  logic [GW-1:0]    grant_id;
  logic             busy;
  logic             overrun;

  flit_tx_arbiter #(.NUM_REQ(NR), .FLIT_WIDTH(FW), .MAX_FLITS(MF)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_flit(req_flit), .req_last(req_last),
    .req_ready(req_ready),
    .out_valid(out_valid), .out_flit(out_flit), .out_last(out_last),
    .out_ready(out_ready),
    .grant_id(grant_id), .busy(busy), .overrun(overrun)
  );

  // ---------------- bookkeeping ----------------
  int errors = 0;
  int checks = 0;
  int xfer_cnt = 0;
  int ovr_cnt = 0;
  int idle_wait = 0;
  logic ovr_prev = 1'b0;

  logic [EW-1:0] exp_q[$];       // {grant_id, last, flit} in expected order
  logic [FW:0]   src_q[NR][$];   // per-requester {last, flit} still to send
  logic [EW-1:0] mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      check("ready_onehot", 32'($onehot0(req_ready)), 32'd1);
      check("ready_route", 32'(req_ready), busy ? 32'(NR'(out_ready) << grant_id) : 32'd0);
      if (overrun) begin
        ovr_cnt++;
        check("overrun_idle", 32'(busy), 32'd0);
        check("overrun_width", 32'(ovr_prev), 32'd0);
      end
      ovr_prev = overrun;
      if (!busy && |req_valid) idle_wait++;
      if (out_valid && out_ready) begin
        xfer_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_xfer: got flit %0h gid %0d expected none", out_flit, grant_id);
        end else begin
          mon_e = exp_q.pop_front();
          check("xfer_gid", 32'(grant_id), 32'(mon_e[EW-1 -: GW]));
          check("xfer_last", 32'(out_last), 32'(mon_e[FW]));
          check("xfer_flit", 32'(out_flit), 32'(mon_e[FW-1:0]));
        end
      end else if (out_valid && exp_q.size() > 0) begin
        mon_e = exp_q[0];
        check("hold_flit", 32'(out_flit), 32'(mon_e[FW-1:0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic present();
    logic [FW:0] h;
    for (int i = 0; i < NR; i++) begin
      if (src_q[i].size() > 0) begin
        h = src_q[i][0];
        req_valid[i] = 1'b1;
        req_flit[i*FW +: FW] = h[FW-1:0];
        req_last[i] = h[FW];
      end else begin
        req_valid[i] = 1'b0;
        req_flit[i*FW +: FW] = '0;
        req_last[i] = 1'b0;
      end
    end
  endtask

  // One clock: note which requesters transfer, then advance their sources.
  task automatic step();
    logic [NR-1:0] xfer;
    @(negedge clk);
    xfer = req_valid & req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) if (xfer[i]) void'(src_q[i].pop_front());
    present();
  endtask

  task automatic add_flit(input int r, input logic [FW-1:0] f, input logic l);
    src_q[r].push_back({l, f});
    present();
  endtask

  task automatic exp_flit(input int r, input logic [FW-1:0] f, input logic l);
    exp_q.push_back({GW'(r), l, f});
  endtask

  function automatic logic src_busy();
    logic b = 1'b0;
    for (int i = 0; i < NR; i++) if (src_q[i].size() > 0) b = 1'b1;
    return b;
  endfunction

  task automatic drain(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() > 0 || src_busy() || busy) && n < budget) begin
      step();
      n++;
    end
    check({name, "_drain"}, 32'(exp_q.size() + (src_busy() ? 1000 : 0)), 32'd0);
    if (n >= budget) begin
      for (int i = 0; i < NR; i++) src_q[i].delete();
      exp_q.delete();
      present();
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [NR-1:0] mask;   // requesters loaded with one packet each
    int            len;    // flits per packet, last on the final one
    int            npk;    // packets expected
    logic [1:0]    o0, o1, o2;  // expected grant order
  } vec_t;

  vec_t vtab[8];

  function automatic logic [1:0] ord(input vec_t v, input int k);
    case (k)
      0: return v.o0;
      1: return v.o1;
      default: return v.o2;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish by 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [FW-1:0] pf[NR][8];
    logic [FW-1:0] f6[6];
    logic [FW-1:0] g2[2];
    int x0, o0, w0, n;
    logic phase, started;

    // rr pointer evolves across rows: starts at 2 after the first test.
    vtab[0] = '{3'b111, 1, 3, 2'd2, 2'd0, 2'd1};
    vtab[1] = '{3'b011, 2, 2, 2'd0, 2'd1, 2'd0};
    vtab[2] = '{3'b101, 3, 2, 2'd2, 2'd0, 2'd0};
    vtab[3] = '{3'b100, 4, 1, 2'd2, 2'd0, 2'd0};  // last on the flit limit
    vtab[4] = '{3'b110, 1, 2, 2'd1, 2'd2, 2'd0};
    vtab[5] = '{3'b001, 2, 1, 2'd0, 2'd0, 2'd0};
    vtab[6] = '{3'b101, 1, 2, 2'd2, 2'd0, 2'd0};
    vtab[7] = '{3'b100, 1, 1, 2'd2, 2'd0, 2'd0};

    // ---- reset state ----
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_flit", 32'(out_flit), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_grant", 32'(grant_id), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // ---- single requester, 3-flit packet ----
    for (int k = 0; k < 3; k++) begin
      pf[1][k] = FW'($urandom_range(0, 65535));
      add_flit(1, pf[1][k], k == 2);
      exp_flit(1, pf[1][k], k == 2);
    end
    #1;
    check("t1_idle_valid", 32'(out_valid), 32'd0);
    x0 = xfer_cnt;
    step(); #1;
    check("t1_latency_valid", 32'(out_valid), 32'd1);
    check("t1_grant", 32'(grant_id), 32'd1);
    check("t1_busy", 32'(busy), 32'd1);
    step(); step();
    check("t1_busy_mid", 32'(busy), 32'd1);
    step(); #1;
    check("t1_busy_fall", 32'(busy), 32'd0);
    check("t1_xfers", 32'(xfer_cnt - x0), 32'd3);
    check("t1_exp_empty", 32'(exp_q.size()), 32'd0);

    // ---- table-driven arbitration rows ----
    for (int v = 0; v < 8; v++) begin
      o0 = ovr_cnt;
      for (int r = 0; r < NR; r++) begin
        if (vtab[v].mask[r]) begin
          for (int k = 0; k < vtab[v].len; k++) begin
            pf[r][k] = FW'($urandom_range(0, 65535));
            add_flit(r, pf[r][k], k == vtab[v].len - 1);
          end
        end
      end
      for (int p = 0; p < vtab[v].npk; p++)
        for (int k = 0; k < vtab[v].len; k++)
          exp_flit(int'(ord(vtab[v], p)), pf[ord(vtab[v], p)][k], k == vtab[v].len - 1);
      drain($sformatf("vec%0d", v), 100);
      check($sformatf("vec%0d_no_overrun", v), 32'(ovr_cnt - o0), 32'd0);
    end

    // ---- fairness: everyone always valid, 2-flit packets, two rounds ----
    x0 = xfer_cnt; w0 = idle_wait;
    for (int r = 0; r < NR; r++)
      for (int k = 0; k < 4; k++) begin
        pf[r][k] = FW'($urandom_range(0, 65535));
        add_flit(r, pf[r][k], k == 1 || k == 3);
      end
    for (int rnd = 0; rnd < 2; rnd++)
      for (int r = 0; r < NR; r++)
        for (int k = 0; k < 2; k++)
          exp_flit(r, pf[r][rnd*2 + k], k == 1);
    drain("fair", 100);
    check("fair_xfers", 32'(xfer_cnt - x0), 32'd12);
    check("fair_idle_cycles", 32'(idle_wait - w0), 32'd6);

    // ---- backpressure on a 4-flit packet from requester 2 ----
    x0 = xfer_cnt; o0 = ovr_cnt;
    for (int k = 0; k < 4; k++) begin
      pf[2][k] = FW'($urandom_range(0, 65535));
      add_flit(2, pf[2][k], k == 3);
      exp_flit(2, pf[2][k], k == 3);
    end
    phase = 1'b1; started = 1'b0; n = 0;
    while (!(started && !busy) && n < 40) begin
      step(); #1;
      if (busy) begin
        started = 1'b1;
        out_ready = phase;
        phase = ~phase;
        #1;
        check("bp_ready_mirror", 32'(req_ready[2]), 32'(out_ready));
        check("bp_other_ready", 32'(req_ready[1:0]), 32'd0);
      end
      n++;
    end
    out_ready = 1'b1;
    check("bp_xfers", 32'(xfer_cnt - x0), 32'd4);
    check("bp_no_overrun", 32'(ovr_cnt - o0), 32'd0);

    // ---- forced release: requester 0 streams 6 flits, requester 1 waits ----
    o0 = ovr_cnt;
    for (int k = 0; k < 6; k++) begin
      f6[k] = FW'($urandom_range(0, 65535));
      add_flit(0, f6[k], k == 5);
    end
    for (int k = 0; k < 2; k++) begin
      g2[k] = FW'($urandom_range(0, 65535));
      add_flit(1, g2[k], k == 1);
    end
    for (int k = 0; k < 4; k++) exp_flit(0, f6[k], 1'b0);
    for (int k = 0; k < 2; k++) exp_flit(1, g2[k], k == 1);
    exp_flit(0, f6[4], 1'b0);
    exp_flit(0, f6[5], 1'b1);
    drain("ovr", 100);
    check("ovr_pulses", 32'(ovr_cnt - o0), 32'd1);

    // ---- reset mid-packet (rr_ptr is 1 here, so requester 1 wins first) ----
    o0 = ovr_cnt;
    for (int k = 0; k < 5; k++) begin
      pf[1][k] = FW'($urandom_range(0, 65535));
      add_flit(1, pf[1][k], k == 4);
    end
    for (int k = 0; k < 2; k++) begin
      pf[0][k] = FW'($urandom_range(0, 65535));
      pf[2][k] = FW'($urandom_range(0, 65535));
      add_flit(0, pf[0][k], k == 1);
      add_flit(2, pf[2][k], k == 1);
    end
    exp_flit(1, pf[1][0], 1'b0);
    exp_flit(1, pf[1][1], 1'b0);
    x0 = xfer_cnt; n = 0;
    while ((xfer_cnt - x0) < 2 && n < 20) begin
      step();
      n++;
    end
    check("rm_two_flits", 32'(xfer_cnt - x0), 32'd2);
    #1 rst_n = 1'b0;
    #1;
    check("rm_out_valid", 32'(out_valid), 32'd0);
    check("rm_busy", 32'(busy), 32'd0);
    check("rm_ready", 32'(req_ready), 32'd0);
    check("rm_out_flit", 32'(out_flit), 32'd0);
    check("rm_out_last", 32'(out_last), 32'd0);
    check("rm_grant", 32'(grant_id), 32'd0);
    check("rm_exp_empty", 32'(exp_q.size()), 32'd0);
    step();
    check("rm_no_pop", 32'(src_q[1].size()), 32'd3);
    rst_n = 1'b1;
    #1;
    check("rm_post_busy", 32'(busy), 32'd0);
    check("rm_post_grant", 32'(grant_id), 32'd0);
    exp_flit(0, pf[0][0], 1'b0);
    exp_flit(0, pf[0][1], 1'b1);
    for (int k = 2; k < 5; k++) exp_flit(1, pf[1][k], k == 4);
    exp_flit(2, pf[2][0], 1'b0);
    exp_flit(2, pf[2][1], 1'b1);
    drain("rm", 100);
    check("rm_no_overrun", 32'(ovr_cnt - o0), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
